// File: rtl/button_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : button_pulse_gen
// Description : Turns a raw bouncing push-button into one clkEN pulse per
//               debounced press, with optional auto-repeat while held.
// Revision    : 1.0 - initial release
// ============================================================================
module button_pulse_gen #(
    parameter int DB_CYCLES     = 4,
    parameter int CNT_W         = 20,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       en,
    output logic       clkEN,
    output logic       btn_level,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fire_d;
    logic             clken_q;
    logic             level_q;
    logic [7:0]       press_cnt_q;

    logic             w_btn_s;
    logic             w_db_tc;
    logic             w_rep_run;
    logic             w_rep_tc;
    logic             w_pulse;

    assign w_btn_s = sync2_q;
    assign w_db_tc = (cnt_q == c_DB_LAST);
    assign w_pulse = fire_d & en;

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            assign w_rep_run = 1'b1;
            assign w_rep_tc  = (cnt_q == c_REP_LAST);
        end else begin : g_no_repeat
            assign w_rep_run = 1'b0;
            assign w_rep_tc  = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_btn_s) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!w_btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (w_db_tc) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    fire_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            ST_HELD: begin
                // Release takes priority over a coincident repeat terminal count.
                if (!w_btn_s) begin
                    state_d = ST_REL_CHK;
                    cnt_d   = '0;
                end else if (w_rep_run) begin
                    if (w_rep_tc) begin
                        cnt_d  = '0;
                        fire_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + c_CNT_ONE;
                    end
                end
            end
            ST_REL_CHK: begin
                if (w_btn_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (w_db_tc) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            clken_q     <= 1'b0;
            level_q     <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clken_q     <= w_pulse;
            level_q     <= (state_d == ST_HELD) || (state_d == ST_REL_CHK);
            press_cnt_q <= press_cnt_q + {7'd0, w_pulse};
        end
    end

    assign clkEN     = clken_q;
    assign btn_level = level_q;
    assign press_cnt = press_cnt_q;

endmodule
`default_nettype wire
